// File: rtl/instru_writer_pkg.sv
// Shared constants for the instruction writer: datapath width, Y86-style icodes
// and the helper that sizes the byte-length fields.
package instru_writer_pkg;

    localparam int DATA_WID = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ICODE_MAX = IPOPQ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Width needed to hold the longest instruction length (2 + constant bytes).
    function automatic int len_w(input int dw);
        return $clog2(dw / 8 + 3);
    endfunction

endpackage

// File: rtl/instru_writer_if.sv
// Instruction-in / byte-write-out bus of the instruction writer.
interface instru_writer_if
    import instru_writer_pkg::*;
#(
    parameter int DATA_WID = instru_writer_pkg::DATA_WID
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [3:0]          rA;
    logic [3:0]          rB;
    logic [DATA_WID-1:0] valC;
    logic                addr_load;
    logic [DATA_WID-1:0] start_addr;
    logic                mem_we;
    logic [DATA_WID-1:0] mem_addr;
    logic [7:0]          mem_wdata;
    logic [DATA_WID-1:0] next_pc;
    logic                busy;
    logic                err;

    modport master (
        output in_valid, icode, ifun, rA, rB, valC, addr_load, start_addr,
        input  in_ready, mem_we, mem_addr, mem_wdata, next_pc, busy, err
    );

    modport slave (
        input  in_valid, icode, ifun, rA, rB, valC, addr_load, start_addr,
        output in_ready, mem_we, mem_addr, mem_wdata, next_pc, busy, err
    );
endinterface

// File: rtl/instru_writer_instr_len.sv
// Combinational icode decode: instruction length and which optional fields exist.
// Kept standalone so the fetch stage can share the same table.
module instr_len
    import instru_writer_pkg::*;
#(
    parameter int DATA_WID = instru_writer_pkg::DATA_WID,
    parameter int LEN_W    = len_w(DATA_WID)
) (
    input  logic [3:0]       icode,
    output logic [LEN_W-1:0] len,
    output logic             has_reg,
    output logic             has_valc,
    output logic             valid
);
    localparam int NBYTES = DATA_WID / 8;

    always_comb begin
        len      = '0;
        has_reg  = 1'b0;
        has_valc = 1'b0;
        valid    = 1'b1;
        case (icode)
            IHALT, INOP, IRET: begin
                len = LEN_W'(1);
            end
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                len     = LEN_W'(2);
                has_reg = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                len      = LEN_W'(2 + NBYTES);
                has_reg  = 1'b1;
                has_valc = 1'b1;
            end
            IJXX, ICALL: begin
                len      = LEN_W'(1 + NBYTES);
                has_valc = 1'b1;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instru_writer.sv
// Serialises one accepted instruction into instruction memory, one byte per
// cycle, starting at the write pointer next_pc.
module instru_writer
    import instru_writer_pkg::*;
#(
    parameter int DATA_WID = instru_writer_pkg::DATA_WID
) (
    input logic            clk,
    input logic            rst_n,
    instru_writer_if.slave bus
);
    localparam int LEN_W = len_w(DATA_WID);

    state_t              state;
    logic [LEN_W-1:0]    byte_idx;
    logic [DATA_WID-1:0] next_pc;
    logic                busy_q;
    logic                err_q;

    logic [3:0]          icode_q;
    logic [3:0]          ifun_q;
    logic [3:0]          ra_q;
    logic [3:0]          rb_q;
    logic [DATA_WID-1:0] valc_q;
    logic [LEN_W-1:0]    len_q;
    logic                has_reg_q;
    logic                has_valc_q;

    logic [LEN_W-1:0]    dec_len;
    logic                dec_has_reg;
    logic                dec_has_valc;
    logic                dec_valid;
    logic                accept;
    logic [LEN_W-1:0]    vidx;
    logic [7:0]          wbyte;

    instr_len #(
        .DATA_WID (DATA_WID),
        .LEN_W    (LEN_W)
    ) u_len (
        .icode    (bus.icode),
        .len      (dec_len),
        .has_reg  (dec_has_reg),
        .has_valc (dec_has_valc),
        .valid    (dec_valid)
    );

    // A pointer load in the same cycle wins, so acceptance is blocked by it.
    assign bus.in_ready = rst_n && (state == IDLE) && !bus.addr_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            icode_q    <= bus.icode;
            ifun_q     <= bus.ifun;
            ra_q       <= bus.rA;
            rb_q       <= bus.rB;
            valc_q     <= bus.valC;
            len_q      <= dec_len;
            has_reg_q  <= dec_has_reg;
            has_valc_q <= dec_has_valc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            next_pc  <= '0;
            byte_idx <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    byte_idx <= '0;
                    if (bus.addr_load) begin
                        next_pc <= bus.start_addr;
                    end else if (accept) begin
                        if (dec_valid) begin
                            state  <= EMIT;
                            busy_q <= 1'b1;
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (byte_idx == len_q - LEN_W'(1)) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        byte_idx <= '0;
                        next_pc  <= next_pc + DATA_WID'(len_q);
                    end else begin
                        byte_idx <= byte_idx + LEN_W'(1);
                    end
                end
                ERR: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    err_q  <= 1'b0;
                end
            endcase
        end
    end

    // Byte order: opcode byte, optional register byte, then valC little-endian.
    always_comb begin
        wbyte = '0;
        vidx  = has_reg_q ? byte_idx - LEN_W'(2) : byte_idx - LEN_W'(1);
        if (byte_idx == '0) begin
            wbyte = {icode_q, ifun_q};
        end else if (has_reg_q && byte_idx == LEN_W'(1)) begin
            wbyte = {ra_q, rb_q};
        end else if (has_valc_q) begin
            wbyte = 8'(valc_q >> {vidx, 3'b000});
        end
    end

    assign bus.mem_we    = (state == EMIT);
    assign bus.mem_addr  = bus.mem_we ? next_pc + DATA_WID'(byte_idx) : '0;
    assign bus.mem_wdata = bus.mem_we ? wbyte : 8'h00;
    assign bus.next_pc   = next_pc;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: doc/instru_writer.md
INSTRU_WRITER -- requirements
Module: instru_writer

Interface
REQ-001 Parameter DATA_WID, default 64, SHALL set the address width and the valC width; DATA_WID/8 is the valC byte count.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 in_valid  in  1  instruction fields present.
REQ-005 in_ready  out  1  writer can accept; high only in IDLE.
REQ-006 icode  in  4  instruction code.
REQ-007 ifun  in  4  function code.
REQ-008 rA  in  4  register A specifier.
REQ-009 rB  in  4  register B specifier.
REQ-010 valC  in  DATA_WID  constant word.
REQ-011 addr_load  in  1  load write pointer from start_addr.
REQ-012 start_addr  in  DATA_WID  new write pointer.
REQ-013 mem_we  out  1  byte write strobe to instruction memory.
REQ-014 mem_addr  out  DATA_WID  byte address of the current write.
REQ-015 mem_wdata  out  8  byte written.
REQ-016 next_pc  out  DATA_WID  write pointer, i.e. the address after the last completed instruction.
REQ-017 busy  out  1  instruction being emitted.
REQ-018 err  out  1  one-cycle pulse on an invalid icode.

Function
REQ-019 The block SHALL encode one instruction into the byte stream the fetch stage decodes:
- byte0 = {icode,ifun}
- byte1 = {rA,rB}, when the format has a register byte
- then valC, little-endian, when the format has a constant
REQ-020 Lengths by icode SHALL be:
- 0,1,9: 1 byte, byte0 only
- 2,6,A,B: 2 bytes, byte0 and byte1
- 3,4,5: 2+DATA_WID/8 bytes
- 7,8: 1+DATA_WID/8 bytes, with no register byte
REQ-021 FSM states SHALL be IDLE, EMIT and ERR.
REQ-022 IDLE -> EMIT when in_valid && in_ready and icode <= 4'hB; the fields SHALL be latched on that edge.
REQ-023 IDLE -> ERR when an accepted icode > 4'hB; ERR SHALL last one cycle with err=1, no write, and next_pc unchanged; ERR -> IDLE.
REQ-024 In EMIT, exactly one byte SHALL be written per cycle (mem_we=1, mem_addr=next_pc+byte_idx); the first write SHALL occur in the cycle after acceptance.
REQ-025 After the last byte, the FSM SHALL return to IDLE and next_pc SHALL advance by the instruction length in the same edge.
REQ-026 Acceptance at cycle T SHALL give writes in cycles T+1..T+N and in_ready=1 again in cycle T+N+1.
REQ-027 busy SHALL equal (state==EMIT); in_ready SHALL equal (state==IDLE).
REQ-028 Address arithmetic SHALL be modulo 2^DATA_WID; writes past the top address SHALL wrap to 0 with no error.
REQ-029 addr_load in IDLE SHALL set next_pc=start_addr at the next edge.
REQ-030 addr_load outside IDLE SHALL be ignored.
REQ-031 If addr_load and a valid acceptance occur in the same IDLE cycle, addr_load SHALL take priority and in_valid SHALL not be accepted that cycle (in_ready is driven low while addr_load=1).
REQ-032 Input fields SHALL be ignored while not in IDLE; the latched copy SHALL be used throughout EMIT.
REQ-033 mem_addr and mem_wdata SHALL be 0 when mem_we=0.

Reset
REQ-034 rst_n=0 at a rising edge SHALL set: state=IDLE, next_pc=0, byte_idx=0, mem_we=0, err=0, busy=0.
REQ-035 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-036 Reset during EMIT SHALL abort the instruction, with no further writes from the next edge; partially written bytes are not retracted.

Structure
REQ-037 Icode constants (IHALT..IPOPQ) and the valid-icode limit SHALL live in the shared header alongside DATA_WID.
REQ-038 Length and format decode SHALL be one combinational sub-module, instr_len (icode -> length, has_reg, has_valc, valid), reusable by fetch.
REQ-039 The FSM, byte counter, pointer and byte mux SHALL be in instru_writer.

Verification
REQ-040 Reset release, then addr_load start_addr=0, then accept icode=0 ifun=0 -> one write 0x00 @0; next_pc=1.
REQ-041 addr_load 0x10; accept irmovq (icode 3, ifun 0, rA F, rB 2, valC 0x0123456789ABCDEF) -> bytes 30 F2 EF CD AB 89 67 45 23 01 @0x10..0x19 over 10 cycles; next_pc=0x1A.
REQ-042 Back-to-back jXX (icode 7, ifun 0, valC 0x40) then ret (icode 9) from 0 -> 9 writes (70 40 00 00 00 00 00 00 00) @0..8, one idle cycle, then 90 @9; next_pc=0xA.
REQ-043 Accept icode 0xC -> err=1 for exactly one cycle, mem_we never asserted, next_pc unchanged, in_ready back after 2 cycles.
REQ-044 rst_n low after the 3rd byte of a rmmovq -> mem_we=0 from the next edge, next_pc=0, in_ready=1 after release.
REQ-045 addr_load 0xFFFF_FFFF_FFFF_FFFF; accept OPq (icode 6, ifun 0, rA 1, rB 2) -> 60 @max, 12 @0; next_pc=1.
